dmem_aligner: RTL and testbench

Load/store alignment unit between the processor core data port and the word-organised data memory and VRAM. Stores: byte/half-word data is replicated across lanes and a 4-bit write strobe is generated. Loads: the requested lane is extracted from the 32-bit memory word and sign- or zero-extended. Memory read data arrives one cycle after the request, so the unit registers the read attributes for one cycle.

---
 rtl/dmem_aligner.sv | 155 +++++++++++++++
 tb/tb_dmem_aligner.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_aligner.sv
// ---------------------------------------------------------------------------
// dmem_aligner
//
// Load/store alignment unit between the core data port and the word-organised
// data memory / VRAM.
//   Stores : byte and half-word data is replicated across the byte lanes and a
//            4-bit write strobe selects the lanes to write (combinational).
//   Loads  : the load size, sign mode and byte offset are registered for one
//            cycle, because memory read data arrives the cycle after the
//            request. The addressed lane is then extracted from MDATAI and
//            sign- or zero-extended.
//
// Ports
//   CLK      in   1   system clock, rising edge
//   RST      in   1   asynchronous active-high reset (clears load registers)
//   ADDRI    in  32   core byte address
//   DATAI    in  32   core store data, right-justified
//   DATAO    out 32   aligned, extended load data to the core
//   WE       in   2   store size: 00 none, 01 byte, 10 half, 11 word
//   RE       in   2   load size : 00 none, 01 byte, 10 half, 11 word
//   SE       in   1   load sign-extend (1 signed, 0 unsigned)
//   MADDR    out 30   memory word address (ADDRI[31:2])
//   MDATAO   out 32   lane-replicated store data to memory
//   MDATAI   in  32   memory read word, valid the cycle after the request
//   MWSTB    out  4   byte write strobe, bit n enables bits [8n+7:8n]
//   MISALIGN out  1   misaligned access flag
//
// Build option
//   DALIGN_MISALIGN_EN  when defined, misaligned half/word accesses raise
//                       MISALIGN, suppress the store strobe and turn the
//                       load into a no-op. When undefined, MISALIGN is tied
//                       low and misaligned accesses are aligned down.
// ---------------------------------------------------------------------------
module dmem_aligner (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] ADDRI,
   input  logic [31:0] DATAI,
   output logic [31:0] DATAO,
   input  logic [1:0]  WE,
   input  logic [1:0]  RE,
   input  logic        SE,
   output logic [29:0] MADDR,
   output logic [31:0] MDATAO,
   input  logic [31:0] MDATAI,
   output logic [3:0]  MWSTB,
   output logic        MISALIGN
);

   localparam logic [1:0] SZ_NONE = 2'b00;
   localparam logic [1:0] SZ_BYTE = 2'b01;
   localparam logic [1:0] SZ_HALF = 2'b10;
   localparam logic [1:0] SZ_WORD = 2'b11;

   logic [1:0] r_re;
   logic       r_se;
   logic [1:0] r_ofs;

   logic       wr_mis;
   logic       rd_mis;
   logic [1:0] re_eff;

   assign MADDR = ADDRI[31:2];

   // ------------------------------------------------------------------------
   // Misalignment detection
   // ------------------------------------------------------------------------
`ifdef DALIGN_MISALIGN_EN
   assign wr_mis = ((WE == SZ_HALF) && ADDRI[0]) ||
                   ((WE == SZ_WORD) && (ADDRI[1:0] != 2'b00));
   assign rd_mis = ((RE == SZ_HALF) && ADDRI[0]) ||
                   ((RE == SZ_WORD) && (ADDRI[1:0] != 2'b00));
`else
   assign wr_mis = 1'b0;
   assign rd_mis = 1'b0;
`endif

   assign MISALIGN = wr_mis | rd_mis;

   // A misaligned load is captured as "no load" so DATAO reads 0 next cycle.
   assign re_eff = rd_mis ? SZ_NONE : RE;

   // ------------------------------------------------------------------------
   // Store path (combinational)
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path through the case leaves it unassigned (which infers a latch).
      MWSTB  = 4'b0000;
      MDATAO = DATAI;
      case (WE)
         SZ_BYTE: begin
            MWSTB  = 4'b0001 << ADDRI[1:0];
            MDATAO = {4{DATAI[7:0]}};
         end
         SZ_HALF: begin
            // ADDRI[0] is ignored: a half store is aligned down.
            MWSTB  = ADDRI[1] ? 4'b1100 : 4'b0011;
            MDATAO = {2{DATAI[15:0]}};
         end
         SZ_WORD: begin
            MWSTB  = 4'b1111;
            MDATAO = DATAI;
         end
         default: ;
      endcase
      if (wr_mis) MWSTB = 4'b0000;
   end

   // ------------------------------------------------------------------------
   // Load request register: captured unconditionally every cycle, so an idle
   // cycle (RE=00) clears the pending load.
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // update together at the edge regardless of statement order.
      if (RST) begin
         r_re  <= SZ_NONE;
         r_se  <= 1'b0;
         r_ofs <= 2'b00;
      end else begin
         r_re  <= re_eff;
         r_se  <= SE;
         r_ofs <= ADDRI[1:0];
      end
   end

   // ------------------------------------------------------------------------
   // Load path (combinational from registered attributes and MDATAI)
   // ------------------------------------------------------------------------
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      ld_byte = MDATAI[7:0];
      case (r_ofs)
         2'd1:    ld_byte = MDATAI[15:8];
         2'd2:    ld_byte = MDATAI[23:16];
         2'd3:    ld_byte = MDATAI[31:24];
         default: ld_byte = MDATAI[7:0];
      endcase
      ld_half = r_ofs[1] ? MDATAI[31:16] : MDATAI[15:0];
   end

   always_comb begin
      DATAO = 32'h0000_0000;
      case (r_re)
         SZ_BYTE: DATAO = {{24{r_se & ld_byte[7]}}, ld_byte};
         SZ_HALF: DATAO = {{16{r_se & ld_half[15]}}, ld_half};
         SZ_WORD: DATAO = MDATAI;
         default: DATAO = 32'h0000_0000;
      endcase
   end

endmodule

// File: tb/tb_dmem_aligner.sv
// ---------------------------------------------------------------------------
// tb_dmem_aligner
//
// Directed self-checking bench for dmem_aligner. Inputs change 1 time unit
// after the rising clock edge; outputs are sampled 1 time unit later, well
// away from the edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_aligner;

   logic        CLK;
   logic        RST;
   logic [31:0] ADDRI;
   logic [31:0] DATAI;
   logic [31:0] DATAO;
   logic [1:0]  WE;
   logic [1:0]  RE;
   logic        SE;
   logic [29:0] MADDR;
   logic [31:0] MDATAO;
   logic [31:0] MDATAI;
   logic [3:0]  MWSTB;
   logic        MISALIGN;

   int n_cmp;
   int n_err;

   dmem_aligner dut (
      .CLK      (CLK),
      .RST      (RST),
      .ADDRI    (ADDRI),
      .DATAI    (DATAI),
      .DATAO    (DATAO),
      .WE       (WE),
      .RE       (RE),
      .SE       (SE),
      .MADDR    (MADDR),
      .MDATAO   (MDATAO),
      .MDATAI   (MDATAI),
      .MWSTB    (MWSTB),
      .MISALIGN (MISALIGN)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Advance to just after the next rising edge.
   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      ADDRI  = 32'h0;
      DATAI  = 32'h0;
      WE     = 2'b00;
      RE     = 2'b00;
      SE     = 1'b0;
      MDATAI = 32'h0;
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset();
      RST = 1'b1;
      idle_inputs();
      RE     = 2'b11;
      MDATAI = 32'hCAFE_F00D;
      next_cycle();
      #1;
      n_cmp++;
      if (DATAO !== 32'h0) begin
         $display("FAIL reset_hold: DATAO got %h want %h", DATAO, 32'h0);
         n_err++;
      end
      RE  = 2'b00;
      RST = 1'b0;
      next_cycle();
      #1;
      n_cmp++;
      if (DATAO !== 32'h0) begin
         $display("FAIL reset_release: DATAO got %h want %h", DATAO, 32'h0);
         n_err++;
      end
      n_cmp++;
      if (MISALIGN !== 1'b0) begin
         $display("FAIL reset_misalign: MISALIGN got %b want 0", MISALIGN);
         n_err++;
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_store();
      idle_inputs();
      // Byte store at offset 3
      ADDRI = 32'h0010_0003; DATAI = 32'h1234_56A5; WE = 2'b01;
      #1;
      n_cmp++;
      if (MWSTB !== 4'b1000 || MDATAO !== 32'hA5A5_A5A5 || MADDR !== 30'h0004_0000) begin
         $display("FAIL store_byte: MWSTB %b MDATAO %h MADDR %h want 1000 a5a5a5a5 00040000",
                  MWSTB, MDATAO, MADDR);
         n_err++;
      end
      // Byte store at offset 1
      ADDRI = 32'h0010_0001;
      #1;
      n_cmp++;
      if (MWSTB !== 4'b0010) begin
         $display("FAIL store_byte_ofs1: MWSTB got %b want 0010", MWSTB);
         n_err++;
      end
      // Half store at offset 2
      ADDRI = 32'h0010_0002; DATAI = 32'h0000_BEEF; WE = 2'b10;
      #1;
      n_cmp++;
      if (MWSTB !== 4'b1100 || MDATAO !== 32'hBEEF_BEEF) begin
         $display("FAIL store_half: MWSTB %b MDATAO %h want 1100 beefbeef", MWSTB, MDATAO);
         n_err++;
      end
      // Half store at offset 0
      ADDRI = 32'h0010_0000; DATAI = 32'hFFFF_1357;
      #1;
      n_cmp++;
      if (MWSTB !== 4'b0011 || MDATAO !== 32'h1357_1357) begin
         $display("FAIL store_half_lo: MWSTB %b MDATAO %h want 0011 13571357", MWSTB, MDATAO);
         n_err++;
      end
      // Word store
      ADDRI = 32'h0010_0000; DATAI = 32'hDEAD_BEEF; WE = 2'b11;
      #1;
      n_cmp++;
      if (MWSTB !== 4'b1111 || MDATAO !== 32'hDEAD_BEEF) begin
         $display("FAIL store_word: MWSTB %b MDATAO %h want 1111 deadbeef", MWSTB, MDATAO);
         n_err++;
      end
      // No store
      WE = 2'b00; DATAI = 32'h0102_0304; ADDRI = 32'hFFFF_FFFC;
      #1;
      n_cmp++;
      if (MWSTB !== 4'b0000 || MDATAO !== 32'h0102_0304 || MADDR !== 30'h3FFF_FFFF) begin
         $display("FAIL store_none: MWSTB %b MDATAO %h MADDR %h want 0000 01020304 3fffffff",
                  MWSTB, MDATAO, MADDR);
         n_err++;
      end
      idle_inputs();
   endtask

   // -------------------------------------------------------------------------
   task automatic test_load();
      logic [31:0] exp_s [4];
      logic [31:0] exp_u [4];
      exp_s[0] = 32'h0000_0020; exp_u[0] = 32'h0000_0020;
      exp_s[1] = 32'hFFFF_FFC0; exp_u[1] = 32'h0000_00C0;
      exp_s[2] = 32'h0000_0040; exp_u[2] = 32'h0000_0040;
      exp_s[3] = 32'hFFFF_FF80; exp_u[3] = 32'h0000_0080;

      idle_inputs();
      // Directed byte load from the plan, signed then unsigned
      ADDRI = 32'h0010_0001; RE = 2'b01; SE = 1'b1;
      next_cycle();
      idle_inputs();
      MDATAI = 32'h1122_8344;
      #1;
      n_cmp++;
      if (DATAO !== 32'hFFFF_FF83) begin
         $display("FAIL load_byte_s: DATAO got %h want ffffff83", DATAO);
         n_err++;
      end
      ADDRI = 32'h0010_0001; RE = 2'b01; SE = 1'b0;
      next_cycle();
      idle_inputs();
      MDATAI = 32'h1122_8344;
      #1;
      n_cmp++;
      if (DATAO !== 32'h0000_0083) begin
         $display("FAIL load_byte_u: DATAO got %h want 00000083", DATAO);
         n_err++;
      end

      // Every byte offset, both sign modes
      for (int ofs = 0; ofs < 4; ofs++) begin
         for (int s = 0; s < 2; s++) begin
            idle_inputs();
            ADDRI = 32'h0000_2000 | 32'(ofs); RE = 2'b01; SE = s[0];
            next_cycle();
            idle_inputs();
            MDATAI = 32'h8040_C020;
            #1;
            n_cmp++;
            if (DATAO !== (s[0] ? exp_s[ofs] : exp_u[ofs])) begin
               $display("FAIL load_byte_ofs%0d_se%0d: DATAO got %h want %h",
                        ofs, s, DATAO, (s[0] ? exp_s[ofs] : exp_u[ofs]));
               n_err++;
            end
         end
      end

      // Half loads
      idle_inputs();
      ADDRI = 32'h0010_0002; RE = 2'b10; SE = 1'b1;
      next_cycle();
      idle_inputs();
      MDATAI = 32'h8001_7FFF;
      #1;
      n_cmp++;
      if (DATAO !== 32'hFFFF_8001) begin
         $display("FAIL load_half_hi_s: DATAO got %h want ffff8001", DATAO);
         n_err++;
      end
      ADDRI = 32'h0010_0000; RE = 2'b10; SE = 1'b1;
      next_cycle();
      idle_inputs();
      MDATAI = 32'h8001_7FFF;
      #1;
      n_cmp++;
      if (DATAO !== 32'h0000_7FFF) begin
         $display("FAIL load_half_lo_s: DATAO got %h want 00007fff", DATAO);
         n_err++;
      end
      ADDRI = 32'h0010_0002; RE = 2'b10; SE = 1'b0;
      next_cycle();
      idle_inputs();
      MDATAI = 32'h8001_7FFF;
      #1;
      n_cmp++;
      if (DATAO !== 32'h0000_8001) begin
         $display("FAIL load_half_hi_u: DATAO got %h want 00008001", DATAO);
         n_err++;
      end

      // Word load, sign mode ignored
      ADDRI = 32'h0010_0000; RE = 2'b11; SE = 1'b1;
      next_cycle();
      idle_inputs();
      MDATAI = 32'h8000_0001;
      #1;
      n_cmp++;
      if (DATAO !== 32'h8000_0001) begin
         $display("FAIL load_word: DATAO got %h want 80000001", DATAO);
         n_err++;
      end
      idle_inputs();
      next_cycle();
   endtask

   // -------------------------------------------------------------------------
   task automatic test_back_to_back();
      idle_inputs();
      // Cycle N: byte load offset 0, unsigned
      ADDRI = 32'h0000_0100; RE = 2'b01; SE = 1'b0;
      next_cycle();
      // Cycle N+1: half load offset 2, unsigned; data for N arrives
      ADDRI = 32'h0000_0102; RE = 2'b10; SE = 1'b0;
      MDATAI = 32'h1234_5678;
      #1;
      n_cmp++;
      if (DATAO !== 32'h0000_0078) begin
         $display("FAIL b2b_first: DATAO got %h want 00000078", DATAO);
         n_err++;
      end
      next_cycle();
      // Cycle N+2: idle; data for N+1 arrives
      ADDRI = 32'h0; RE = 2'b00; SE = 1'b1;
      MDATAI = 32'hAABB_CCDD;
      #1;
      n_cmp++;
      if (DATAO !== 32'h0000_AABB) begin
         $display("FAIL b2b_second: DATAO got %h want 0000aabb", DATAO);
         n_err++;
      end
      next_cycle();
      // Cycle N+3: no load pending
      MDATAI = 32'hFFFF_FFFF;
      #1;
      n_cmp++;
      if (DATAO !== 32'h0) begin
         $display("FAIL b2b_idle: DATAO got %h want 00000000", DATAO);
         n_err++;
      end
      idle_inputs();
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset_pending();
      idle_inputs();
      ADDRI = 32'h0010_0000; RE = 2'b11;
      next_cycle();
      idle_inputs();
      MDATAI = 32'hDEAD_BEEF;
      #1;
      n_cmp++;
      if (DATAO !== 32'hDEAD_BEEF) begin
         $display("FAIL rst_pend_before: DATAO got %h want deadbeef", DATAO);
         n_err++;
      end
      // Asynchronous reset pulse in the data cycle, well before the next edge
      RST = 1'b1;
      #1;
      n_cmp++;
      if (DATAO !== 32'h0) begin
         $display("FAIL rst_pend_during: DATAO got %h want 00000000", DATAO);
         n_err++;
      end
      RST = 1'b0;
      #1;
      n_cmp++;
      if (DATAO !== 32'h0) begin
         $display("FAIL rst_pend_after: DATAO got %h want 00000000", DATAO);
         n_err++;
      end
      next_cycle();
   endtask

   // -------------------------------------------------------------------------
   task automatic test_misalign();
      idle_inputs();
      ADDRI = 32'h0010_0002; DATAI = 32'h0A0B_0C0D; WE = 2'b11;
      #1;
`ifdef DALIGN_MISALIGN_EN
      n_cmp++;
      if (MISALIGN !== 1'b1 || MWSTB !== 4'b0000) begin
         $display("FAIL mis_store_word: MISALIGN %b MWSTB %b want 1 0000", MISALIGN, MWSTB);
         n_err++;
      end
`else
      n_cmp++;
      if (MISALIGN !== 1'b0 || MWSTB !== 4'b1111 || MDATAO !== 32'h0A0B_0C0D) begin
         $display("FAIL mis_store_word: MISALIGN %b MWSTB %b MDATAO %h want 0 1111 0a0b0c0d",
                  MISALIGN, MWSTB, MDATAO);
         n_err++;
      end
`endif
      // Half store at odd address offset 3
      ADDRI = 32'h0010_0003; DATAI = 32'h0000_5AA5; WE = 2'b10;
      #1;
`ifdef DALIGN_MISALIGN_EN
      n_cmp++;
      if (MISALIGN !== 1'b1 || MWSTB !== 4'b0000) begin
         $display("FAIL mis_store_half: MISALIGN %b MWSTB %b want 1 0000", MISALIGN, MWSTB);
         n_err++;
      end
`else
      n_cmp++;
      if (MISALIGN !== 1'b0 || MWSTB !== 4'b1100 || MDATAO !== 32'h5AA5_5AA5) begin
         $display("FAIL mis_store_half: MISALIGN %b MWSTB %b MDATAO %h want 0 1100 5aa55aa5",
                  MISALIGN, MWSTB, MDATAO);
         n_err++;
      end
`endif
      // Half load at offset 3, unsigned
      idle_inputs();
      ADDRI = 32'h0010_0003; RE = 2'b10; SE = 1'b0;
      #1;
`ifdef DALIGN_MISALIGN_EN
      n_cmp++;
      if (MISALIGN !== 1'b1) begin
         $display("FAIL mis_load_flag: MISALIGN got %b want 1", MISALIGN);
         n_err++;
      end
`endif
      next_cycle();
      idle_inputs();
      MDATAI = 32'h1234_5678;
      #1;
`ifdef DALIGN_MISALIGN_EN
      n_cmp++;
      if (DATAO !== 32'h0) begin
         $display("FAIL mis_load_data: DATAO got %h want 00000000", DATAO);
         n_err++;
      end
`else
      n_cmp++;
      if (DATAO !== 32'h0000_1234) begin
         $display("FAIL mis_load_data: DATAO got %h want 00001234", DATAO);
         n_err++;
      end
`endif
      idle_inputs();
      next_cycle();
   endtask

   // -------------------------------------------------------------------------
   initial begin
      n_cmp = 0;
      n_err = 0;
      RST   = 1'b1;
      idle_inputs();
      test_reset();
      test_store();
      test_load();
      test_back_to_back();
      test_reset_pending();
      test_misalign();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Safety bound so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1);
   end

endmodule
